// File: rtl/lp805x_sfrbus_bridge_if.sv
// Core/peripheral SFR access bundle for the lp805x SFR bus bridge.
// master = core strobes plus peripheral responders, slave = the bridge.
interface lp805x_sfrbus_bridge_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NSLV   = 4
);
  localparam int BW = 2*ADDR_W + DATA_W + 5;

  logic [ADDR_W-1:0]      cpu_wr_addr;
  logic [ADDR_W-1:0]      cpu_rd_addr;
  logic [DATA_W-1:0]      cpu_data_in;
  logic                   cpu_wr;
  logic                   cpu_rd;
  logic                   cpu_bit_in;
  logic                   cpu_wr_bit;
  logic                   cpu_rd_bit;
  logic                   cpu_busy;
  logic                   cpu_done;
  logic [DATA_W-1:0]      cpu_data_out;
  logic                   cpu_bit_out;
  logic                   cpu_drop;
  logic                   load;
  logic [BW-1:0]          sfr_bus;
  logic [NSLV-1:0]        slv_sel;
  logic [NSLV*DATA_W-1:0] slv_data;
  logic [NSLV-1:0]        slv_bit;

  modport master (
    output cpu_wr_addr, cpu_rd_addr, cpu_data_in, cpu_wr, cpu_rd,
           cpu_bit_in, cpu_wr_bit, cpu_rd_bit, slv_sel, slv_data, slv_bit,
    input  cpu_busy, cpu_done, cpu_data_out, cpu_bit_out, cpu_drop,
           load, sfr_bus
  );

  modport slave (
    input  cpu_wr_addr, cpu_rd_addr, cpu_data_in, cpu_wr, cpu_rd,
           cpu_bit_in, cpu_wr_bit, cpu_rd_bit, slv_sel, slv_data, slv_bit,
    output cpu_busy, cpu_done, cpu_data_out, cpu_bit_out, cpu_drop,
           load, sfr_bus
  );
endinterface

// File: rtl/lp805x_sfrbus_bridge.sv
// Holds one core SFR access, presents it on the packed peripheral bus for one
// load period, then returns the one-hot muxed response with a done pulse.
module lp805x_sfrbus_bridge #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NSLV   = 4,
  parameter int DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  lp805x_sfrbus_bridge_if.slave sfr_if
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] data_in;
    logic              wr;
    logic              rd;
    logic              bit_in;
    logic              wr_bit;
    logic              rd_bit;
  } sfr_req_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  sfr_req_t          req_in, hold_q, hold_d, bus_q, bus_d;
  logic [DATA_W-1:0] data_q, data_d, rsp_data;
  logic              bit_q, bit_d, rsp_bit;
  logic              done_q, drop_q;
  logic              load, req, capture, issue, finish, drop;

  assign load = (cnt_q == CW'(DIV - 1));
  assign cnt_d = load ? '0 : cnt_q + CW'(1);

  assign req = sfr_if.cpu_wr | sfr_if.cpu_rd | sfr_if.cpu_wr_bit | sfr_if.cpu_rd_bit;
  assign req_in = '{wr_addr: sfr_if.cpu_wr_addr, rd_addr: sfr_if.cpu_rd_addr,
                    data_in: sfr_if.cpu_data_in, wr: sfr_if.cpu_wr, rd: sfr_if.cpu_rd,
                    bit_in: sfr_if.cpu_bit_in, wr_bit: sfr_if.cpu_wr_bit,
                    rd_bit: sfr_if.cpu_rd_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req)  state_d = S_PEND;
      S_PEND:   if (load) state_d = S_ACTIVE;
      S_ACTIVE: if (load) state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  // A request seen in any non-idle state, including the finishing cycle, is dropped.
  always_comb begin
    capture = (state_q == S_IDLE) && req;
    issue   = (state_q == S_PEND) && load;
    finish  = (state_q == S_ACTIVE) && load;
    drop    = (state_q != S_IDLE) && req;
  end

  // OR of all selected slaves; an access nobody claims reads as all ones.
  always_comb begin
    rsp_data = '0;
    rsp_bit  = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (sfr_if.slv_sel[i]) begin
        rsp_data = rsp_data | sfr_if.slv_data[i*DATA_W +: DATA_W];
        rsp_bit  = rsp_bit | sfr_if.slv_bit[i];
      end
    end
    if (sfr_if.slv_sel == '0) rsp_data = '1;
  end

  always_comb begin
    hold_d = capture ? req_in : hold_q;
    bus_d  = issue ? hold_q : (finish ? '0 : bus_q);
    data_d = finish ? rsp_data : data_q;
    bit_d  = finish ? rsp_bit : bit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      hold_q <= '0;
      bus_q  <= '0;
      data_q <= '0;
      bit_q  <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      bus_q  <= bus_d;
      data_q <= data_d;
      bit_q  <= bit_d;
      done_q <= finish;
      drop_q <= drop;
    end
  end

  assign sfr_if.load         = load;
  assign sfr_if.sfr_bus      = bus_q;
  assign sfr_if.cpu_busy     = (state_q != S_IDLE);
  assign sfr_if.cpu_done     = done_q;
  assign sfr_if.cpu_drop     = drop_q;
  assign sfr_if.cpu_data_out = data_q;
  assign sfr_if.cpu_bit_out  = bit_q;
endmodule

// File: tb/tb_lp805x_sfrbus_bridge.sv
// Directed bench for lp805x_sfrbus_bridge: a DIV=4 and a DIV=1 instance share
// clock and reset; each step checks hand-computed bus, timing and response values.
module tb_lp805x_sfrbus_bridge;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NS = 4;
  localparam int BW = 2*AW + DW + 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  lp805x_sfrbus_bridge_if #(.DATA_W(DW), .ADDR_W(AW), .NSLV(NS)) if4 ();
  lp805x_sfrbus_bridge_if #(.DATA_W(DW), .ADDR_W(AW), .NSLV(NS)) if1 ();

  lp805x_sfrbus_bridge #(.DATA_W(DW), .ADDR_W(AW), .NSLV(NS), .DIV(4)) u4 (
    .clk(clk), .rst(rst), .sfr_if(if4)
  );
  lp805x_sfrbus_bridge #(.DATA_W(DW), .ADDR_W(AW), .NSLV(NS), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .sfr_if(if1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cpu4();
    if4.cpu_wr_addr = '0; if4.cpu_rd_addr = '0; if4.cpu_data_in = '0;
    if4.cpu_wr = 1'b0; if4.cpu_rd = 1'b0; if4.cpu_bit_in = 1'b0;
    if4.cpu_wr_bit = 1'b0; if4.cpu_rd_bit = 1'b0;
  endtask

  task automatic clear_cpu1();
    if1.cpu_wr_addr = '0; if1.cpu_rd_addr = '0; if1.cpu_data_in = '0;
    if1.cpu_wr = 1'b0; if1.cpu_rd = 1'b0; if1.cpu_bit_in = 1'b0;
    if1.cpu_wr_bit = 1'b0; if1.cpu_rd_bit = 1'b0;
  endtask

  // Runs ncyc edges on the DIV=4 instance after a request has been set up.
  // Index i means "observed just after the i-th edge", edge 1 being the request edge.
  task automatic watch4(input int ncyc, input logic [BW-1:0] exp_bus, input bit inject,
                        output int n_done, output int n_drop, output int bus_cyc,
                        output int bad_bus, output int first_bus, output int first_done,
                        output logic [DW-1:0] data_at_done, output logic bit_at_done);
    n_done = 0; n_drop = 0; bus_cyc = 0; bad_bus = 0;
    first_bus = -1; first_done = -1; data_at_done = '0; bit_at_done = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      tick();
      clear_cpu4();
      if (i == 1 && inject) begin
        if4.cpu_wr = 1'b1; if4.cpu_wr_addr = 8'h33; if4.cpu_data_in = 8'h44;
      end
      if (if4.cpu_done) begin
        n_done++;
        if (first_done < 0) begin
          first_done   = i;
          data_at_done = if4.cpu_data_out;
          bit_at_done  = if4.cpu_bit_out;
        end
      end
      if (if4.cpu_drop) n_drop++;
      if (if4.sfr_bus == exp_bus) begin
        bus_cyc++;
        if (first_bus < 0) first_bus = i;
      end else if (if4.sfr_bus != '0) begin
        bad_bus++;
      end
    end
  endtask

  initial begin
    logic [BW-1:0] exp_bus;
    logic [DW-1:0] d_done;
    logic          b_done;
    int            n_done, n_drop, bus_cyc, bad_bus, f_bus, f_done, lat;
    bit            found;

    rst = 1'b1;
    clear_cpu4(); clear_cpu1();
    if4.slv_sel = '0; if4.slv_data = '0; if4.slv_bit = '0;
    if1.slv_sel = '0; if1.slv_data = '0; if1.slv_bit = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_bus4", 64'(if4.sfr_bus), 64'd0);
    chk("rst_busy4", 64'(if4.cpu_busy), 64'd0);
    chk("rst_done4", 64'(if4.cpu_done), 64'd0);
    chk("rst_drop4", 64'(if4.cpu_drop), 64'd0);
    chk("rst_data4", 64'(if4.cpu_data_out), 64'd0);
    chk("rst_bit4", 64'(if4.cpu_bit_out), 64'd0);
    chk("rst_load4", 64'(if4.load), 64'd0);
    chk("rst_load1", 64'(if1.load), 64'd1);
    chk("rst_bus1", 64'(if1.sfr_bus), 64'd0);

    // Byte read, slave 2 selected
    if4.slv_sel  = 4'b0100;
    if4.slv_data = {8'hC3, 8'h5A, 8'hA5, 8'h11};
    if4.slv_bit  = 4'b0100;
    if4.cpu_rd = 1'b1; if4.cpu_rd_addr = 8'h81;
    exp_bus = {8'h00, 8'h81, 8'h00, 5'b01000};
    watch4(20, exp_bus, 1'b0, n_done, n_drop, bus_cyc, bad_bus, f_bus, f_done, d_done, b_done);
    lat = f_done - 1;
    chk("rd_ndone", 64'(n_done), 64'd1);
    chk("rd_bus_cycles", 64'(bus_cyc), 64'd4);
    chk("rd_bad_bus", 64'(bad_bus), 64'd0);
    chk("rd_window_to_done", 64'(f_done - f_bus), 64'd4);
    chk("rd_latency_5_8", 64'(lat >= 5 && lat <= 8), 64'd1);
    chk("rd_data", 64'(d_done), 64'h5A);
    chk("rd_bit", 64'(b_done), 64'd1);
    chk("rd_ndrop", 64'(n_drop), 64'd0);
    chk("rd_data_held", 64'(if4.cpu_data_out), 64'h5A);
    chk("rd_busy_after", 64'(if4.cpu_busy), 64'd0);

    // Bit write on DIV=1, nobody selected -> unmapped response
    if1.slv_sel = 4'b0000; if1.slv_data = 32'h12345678; if1.slv_bit = 4'b1111;
    if1.cpu_wr_bit = 1'b1; if1.cpu_wr_addr = 8'hD7; if1.cpu_bit_in = 1'b1;
    exp_bus = {8'hD7, 8'h00, 8'h00, 5'b00110};
    tick(); clear_cpu1();
    chk("bw_busy_e1", 64'(if1.cpu_busy), 64'd1);
    chk("bw_bus_e1", 64'(if1.sfr_bus), 64'd0);
    chk("bw_done_e1", 64'(if1.cpu_done), 64'd0);
    tick();
    chk("bw_bus_e2", 64'(if1.sfr_bus), 64'(exp_bus));
    chk("bw_done_e2", 64'(if1.cpu_done), 64'd0);
    tick();
    chk("bw_bus_e3", 64'(if1.sfr_bus), 64'd0);
    chk("bw_done_e3", 64'(if1.cpu_done), 64'd1);
    chk("unmapped_data", 64'(if1.cpu_data_out), 64'hFF);
    chk("unmapped_bit", 64'(if1.cpu_bit_out), 64'd0);
    chk("bw_busy_e3", 64'(if1.cpu_busy), 64'd0);
    tick();
    chk("bw_done_e4", 64'(if1.cpu_done), 64'd0);
    chk("unmapped_held", 64'(if1.cpu_data_out), 64'hFF);

    // Dual hit: slaves 0 and 1 selected, unselected slaves drive all ones
    if4.slv_sel  = 4'b0011;
    if4.slv_data = {8'hFF, 8'hFF, 8'h30, 8'h0F};
    if4.slv_bit  = 4'b0010;
    if4.cpu_rd = 1'b1; if4.cpu_rd_addr = 8'h90;
    exp_bus = {8'h00, 8'h90, 8'h00, 5'b01000};
    watch4(20, exp_bus, 1'b0, n_done, n_drop, bus_cyc, bad_bus, f_bus, f_done, d_done, b_done);
    chk("dual_ndone", 64'(n_done), 64'd1);
    chk("dual_data", 64'(d_done), 64'h3F);
    chk("dual_bit", 64'(b_done), 64'd1);

    // Second write while the first is pending is dropped
    if4.cpu_wr = 1'b1; if4.cpu_wr_addr = 8'h11; if4.cpu_data_in = 8'h22;
    exp_bus = {8'h11, 8'h00, 8'h22, 5'b10000};
    watch4(20, exp_bus, 1'b1, n_done, n_drop, bus_cyc, bad_bus, f_bus, f_done, d_done, b_done);
    chk("busy_ndrop", 64'(n_drop), 64'd1);
    chk("busy_ndone", 64'(n_done), 64'd1);
    chk("busy_bus_cycles", 64'(bus_cyc), 64'd4);
    chk("busy_bad_bus", 64'(bad_bus), 64'd0);

    // Request coincident with load is issued one full period later
    for (int k = 0; k < 8 && !if4.load; k++) tick();
    chk("coinc_load_seen", 64'(if4.load), 64'd1);
    if4.cpu_rd = 1'b1; if4.cpu_rd_addr = 8'h42;
    exp_bus = {8'h00, 8'h42, 8'h00, 5'b01000};
    watch4(20, exp_bus, 1'b0, n_done, n_drop, bus_cyc, bad_bus, f_bus, f_done, d_done, b_done);
    chk("coinc_first_bus", 64'(f_bus), 64'd5);
    chk("coinc_first_done", 64'(f_done), 64'd9);
    chk("coinc_bus_cycles", 64'(bus_cyc), 64'd4);

    // Reset while ACTIVE
    if4.cpu_rd = 1'b1; if4.cpu_rd_addr = 8'h55;
    tick(); clear_cpu4();
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (if4.sfr_bus != '0) found = 1'b1;
      else tick();
    end
    chk("rstmid_reached_active", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_bus", 64'(if4.sfr_bus), 64'd0);
    chk("rstmid_busy", 64'(if4.cpu_busy), 64'd0);
    chk("rstmid_done", 64'(if4.cpu_done), 64'd0);
    chk("rstmid_drop", 64'(if4.cpu_drop), 64'd0);
    chk("rstmid_data", 64'(if4.cpu_data_out), 64'd0);
    chk("rstmid_bit", 64'(if4.cpu_bit_out), 64'd0);
    chk("rstmid_load", 64'(if4.load), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_bus = {8'h00, 8'h55, 8'h00, 5'b01000};
    watch4(16, exp_bus, 1'b0, n_done, n_drop, bus_cyc, bad_bus, f_bus, f_done, d_done, b_done);
    chk("rstmid_no_done", 64'(n_done), 64'd0);
    chk("rstmid_no_bus", 64'(bus_cyc), 64'd0);

    if4.slv_sel  = 4'b0100;
    if4.slv_data = {8'hC3, 8'h5A, 8'hA5, 8'h11};
    if4.slv_bit  = 4'b0000;
    if4.cpu_rd = 1'b1; if4.cpu_rd_addr = 8'h81;
    exp_bus = {8'h00, 8'h81, 8'h00, 5'b01000};
    watch4(20, exp_bus, 1'b0, n_done, n_drop, bus_cyc, bad_bus, f_bus, f_done, d_done, b_done);
    chk("post_rst_ndone", 64'(n_done), 64'd1);
    chk("post_rst_data", 64'(d_done), 64'h5A);
    chk("post_rst_bus_cycles", 64'(bus_cyc), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
